// File: rtl/test_monitor_if.sv
// Request/response bus and console stream for the test_monitor peripheral.
interface test_monitor_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        con_valid;
  logic        con_ready;
  logic [7:0]  con_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, con_ready,
    input  req_ready, rsp_valid, rsp_rdata, con_valid, con_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, con_ready,
    output req_ready, rsp_valid, rsp_rdata, con_valid, con_data
  );
endinterface

// File: rtl/test_monitor.sv
// Simulation-control peripheral: test result, console FIFO, cycle counter, watchdog.
// Optional TEST_MONITOR_FREEZE_EN: freeze cycle counter and watchdog once done.
module test_monitor #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned WDOG_W     = 24
) (
  input  logic          clk,
  input  logic          rst,
  test_monitor_if.slave bus,
  output logic          done,
  output logic          pass,
  output logic [30:0]   fail_code
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {RUN, PASS, FAIL, TIMEOUT} state_t;

  state_t             state, state_nxt;
  logic [30:0]        code_nxt;
  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   fifo_cnt;
  logic [63:0]        cycle_cnt;
  logic [31:0]        cycle_hi_shadow;
  logic [WDOG_W-1:0]  wdog;
  logic [31:0]        rdata_c;
  logic [2:0]         sel;
  logic               full, con_pop, push, accept, wr, rd;
  logic               run_en, tohost_hit, wdog_load, wdog_dec, expire;
  logic               addr_unused;

  assign sel         = bus.req_addr[4:2];
  assign addr_unused = ^bus.req_addr[1:0];

  // Console FIFO status and stall: only a console push into a full, non-draining FIFO waits
  assign full          = fifo_cnt == CNT_W'(FIFO_DEPTH);
  assign bus.con_valid = fifo_cnt != '0;
  assign bus.con_data  = fifo_mem[rd_ptr];
  assign con_pop       = bus.con_valid & bus.con_ready;
  assign bus.req_ready = !(full && !con_pop && bus.req_valid && bus.req_we && sel == 3'd1);

  assign accept = bus.req_valid & bus.req_ready;
  assign wr     = accept & bus.req_we;
  assign rd     = accept & ~bus.req_we;
  assign push   = wr && sel == 3'd1;

`ifdef TEST_MONITOR_FREEZE_EN
  assign run_en = state == RUN;
`else
  assign run_en = 1'b1;
`endif

  assign tohost_hit = wr && sel == 3'd0 && bus.req_wdata[0];
  assign wdog_load  = wr && sel == 3'd4 && run_en;
  assign wdog_dec   = !wdog_load && state == RUN && wdog != '0;
  assign expire     = wdog_dec && wdog == WDOG_W'(1);

  // Result FSM: TOHOST beats a coincident watchdog expiry
  always_comb begin
    state_nxt = state;
    code_nxt  = fail_code;
    if (state == RUN) begin
      if (tohost_hit) begin
        if (bus.req_wdata == 32'd1) begin
          state_nxt = PASS;
        end else begin
          state_nxt = FAIL;
          code_nxt  = bus.req_wdata[31:1];
        end
      end else if (expire) begin
        state_nxt = TIMEOUT;
        code_nxt  = '1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_code <= '0;
    end else begin
      state     <= state_nxt;
      done      <= state_nxt != RUN;
      pass      <= state_nxt == PASS;
      fail_code <= code_nxt;
    end
  end

  always_comb begin
    rdata_c = '0;
    case (sel)
      3'd2:    rdata_c = cycle_cnt[31:0];
      3'd3:    rdata_c = cycle_hi_shadow;
      3'd4:    rdata_c = 32'(wdog);
      default: rdata_c = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      cycle_cnt       <= '0;
      cycle_hi_shadow <= '0;
      wdog            <= '0;
    end else begin
      bus.rsp_valid <= accept;
      bus.rsp_rdata <= rd ? rdata_c : 32'd0;
      if (run_en) cycle_cnt <= cycle_cnt + 64'd1;
      // Snapshot the upper half so a LO-then-HI read pair is coherent
      if (rd && sel == 3'd2) cycle_hi_shadow <= cycle_cnt[63:32];
      if (wdog_load) wdog <= bus.req_wdata[WDOG_W-1:0];
      else if (wdog_dec) wdog <= wdog - WDOG_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.req_wdata[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + PTR_W'(1);
      if (con_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, con_pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_test_monitor.sv
// Self-checking bench for test_monitor: directed scenarios plus random traffic vs. a queue-based model.
module tb_test_monitor;

  localparam int unsigned DEPTH     = 8;
  localparam int unsigned WDOG_W    = 24;
  localparam int unsigned WDOG_MASK = (32'd1 << WDOG_W) - 32'd1;
  localparam int ST_RUN = 0, ST_PASS = 1, ST_FAIL = 2, ST_TIMEOUT = 3;

  logic        clk, rst, done, pass;
  logic [30:0] fail_code;
  test_monitor_if tif ();

  test_monitor #(.FIFO_DEPTH(DEPTH), .WDOG_W(WDOG_W)) dut (
    .clk(clk), .rst(rst), .bus(tif), .done(done), .pass(pass), .fail_code(fail_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  longint unsigned m_cnt;
  int unsigned     m_wdog;
  logic [31:0]     m_shadow;
  int              m_st;
  logic [30:0]     m_code;
  logic [7:0]      m_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_wdog = 0; m_shadow = 0; m_st = ST_RUN; m_code = '0;
    m_q.delete();
  endtask

  // One clock: check combinational outputs, advance model, check registered outputs
  task automatic cycle();
    logic        full, pop, rdy, acc, wr, th, frz;
    logic [2:0]  sel;
    logic [31:0] v, rdv;
    int          nst;
    logic [30:0] ncode;
    #1;
    sel  = tif.req_addr[4:2];
    v    = tif.req_wdata;
    full = (m_q.size() == DEPTH);
    pop  = (m_q.size() != 0) && tif.con_ready;
    rdy  = !(full && !pop && tif.req_valid && tif.req_we && sel == 3'd1);
    check("req_ready", tif.req_ready, rdy);
    check("con_valid", tif.con_valid, m_q.size() != 0);
    if (m_q.size() != 0) check("con_data", tif.con_data, m_q[0]);
    acc = tif.req_valid && rdy;
    wr  = acc && tif.req_we;
    rdv = 0;
    if (acc && !tif.req_we) begin
      case (sel)
        3'd2:    rdv = m_cnt[31:0];
        3'd3:    rdv = m_shadow;
        3'd4:    rdv = m_wdog;
        default: rdv = 0;
      endcase
    end
`ifdef TEST_MONITOR_FREEZE_EN
    frz = (m_st != ST_RUN);
`else
    frz = 1'b0;
`endif
    nst = m_st; ncode = m_code;
    th  = wr && sel == 3'd0 && v[0];
    if (m_st == ST_RUN && th) begin
      if (v == 32'd1) nst = ST_PASS;
      else begin nst = ST_FAIL; ncode = v[31:1]; end
    end
    if (wr && sel == 3'd4 && !frz) m_wdog = v & WDOG_MASK;
    else if (m_st == ST_RUN && m_wdog != 0) begin
      if (m_wdog == 1 && !th) begin nst = ST_TIMEOUT; ncode = '1; end
      m_wdog = m_wdog - 1;
    end
    if (acc && !tif.req_we && sel == 3'd2) m_shadow = m_cnt[63:32];
    if (!frz) m_cnt = m_cnt + 1;
    if (pop) void'(m_q.pop_front());
    if (wr && sel == 3'd1) m_q.push_back(v[7:0]);
    m_st = nst; m_code = ncode;
    @(posedge clk);
    @(negedge clk);
    check("rsp_valid", tif.rsp_valid, acc);
    check("rsp_rdata", tif.rsp_rdata, rdv);
    check("done", done, m_st != ST_RUN);
    check("pass", pass, m_st == ST_PASS);
    check("fail_code", fail_code, m_code);
  endtask

  task automatic req(input logic we, input logic [4:0] addr, input logic [31:0] data);
    tif.req_valid = 1'b1; tif.req_we = we; tif.req_addr = addr; tif.req_wdata = data;
    cycle();
    tif.req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    tif.req_valid = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    tif.req_valid = 1'b0; tif.req_we = 1'b0; tif.req_addr = '0; tif.req_wdata = '0;
    tif.con_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_code", fail_code, 31'd0);
    check("rst_rsp_valid", tif.rsp_valid, 1'b0);
    check("rst_con_valid", tif.con_valid, 1'b0);
    check("rst_req_ready", tif.req_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [2:0]  a;
    logic [31:0] d;
    rst = 1'b1;
    do_reset();

    // Pass, then a later TOHOST write is ignored
    req(1'b1, 5'h00, 32'h1);
    check("t1_pass", pass, 1'b1);
    check("t1_code", fail_code, 31'd0);
    req(1'b1, 5'h00, 32'h7);
    check("t1_sticky", pass, 1'b1);

    // Even TOHOST value ignored, then fail code 3
    do_reset();
    req(1'b1, 5'h00, 32'h2);
    check("t2_ignored", done, 1'b0);
    req(1'b1, 5'h00, 32'h7);
    check("t2_done", done, 1'b1);
    check("t2_code", fail_code, 31'd3);

    // Fill FIFO, stall the 9th byte, then drain in order
    do_reset();
    for (int i = 0; i < 8; i++) req(1'b1, 5'h04, 32'h41 + i);
    tif.req_valid = 1'b1; tif.req_we = 1'b1; tif.req_addr = 5'h04; tif.req_wdata = 32'h49;
    cycle();
    check("t3_stall", tif.req_ready, 1'b0);
    tif.con_ready = 1'b1;
    cycle();
    idle(10);
    check("t3_empty", tif.con_valid, 1'b0);

    // Watchdog expiry, and TOHOST winning in the expiry cycle
    do_reset();
    req(1'b1, 5'h10, 32'd5);
    idle(4);
    check("t4_not_yet", done, 1'b0);
    idle(1);
    check("t4_done", done, 1'b1);
    check("t4_code", fail_code, 31'h7FFF_FFFF);
    do_reset();
    req(1'b1, 5'h10, 32'd5);
    idle(4);
    req(1'b1, 5'h00, 32'h1);
    check("t4b_pass", pass, 1'b1);
    check("t4b_code", fail_code, 31'd0);

    // Cycle-counter snapshot with a forced counter value
    do_reset();
    idle(3);
    force dut.cycle_cnt = 64'h0000_0001_FFFF_FFFF;
    tif.req_valid = 1'b1; tif.req_we = 1'b0; tif.req_addr = 5'h08;
    @(posedge clk); @(negedge clk);
    check("t5_lo_valid", tif.rsp_valid, 1'b1);
    check("t5_lo", tif.rsp_rdata, 32'hFFFF_FFFF);
    release dut.cycle_cnt;
    tif.req_addr = 5'h0C;
    @(posedge clk); @(negedge clk);
    check("t5_hi_valid", tif.rsp_valid, 1'b1);
    check("t5_hi", tif.rsp_rdata, 32'h1);
    tif.req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check("t5_idle_valid", tif.rsp_valid, 1'b0);
    tif.req_valid = 1'b1; tif.req_addr = 5'h08;
    @(posedge clk); @(negedge clk);
    tif.req_addr = 5'h0C;
    @(posedge clk); @(negedge clk);
    check("t5_hi2", tif.rsp_rdata, 32'h2);
    tif.req_valid = 1'b0;

    // Random traffic against the model
    for (int run = 0; run < 4; run++) begin
      do_reset();
      for (int c = 0; c < 600; c++) begin
        a = 3'($urandom_range(0, 7));
        d = $urandom;
        if (a == 3'd0 && $urandom_range(0, 31) != 0) d[0] = 1'b0;
        if (a == 3'd4) d = $urandom_range(0, 40);
        tif.req_valid = ($urandom_range(0, 3) != 0);
        tif.req_we    = 1'($urandom_range(0, 1));
        tif.req_addr  = {a, 2'($urandom_range(0, 3))};
        tif.req_wdata = d;
        tif.con_ready = ($urandom_range(0, 2) == 0);
        cycle();
      end
    end

    // Reset in the middle of FAIL with bytes queued and a response in flight
    do_reset();
    req(1'b1, 5'h00, 32'h7);
    req(1'b1, 5'h04, 32'h58);
    req(1'b1, 5'h04, 32'h59);
    tif.req_valid = 1'b1; tif.req_we = 1'b0; tif.req_addr = 5'h08;
    @(posedge clk);
    #2;
    check("t6_pre_rsp", tif.rsp_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("t6_done", done, 1'b0);
    check("t6_con_valid", tif.con_valid, 1'b0);
    check("t6_rsp_valid", tif.rsp_valid, 1'b0);
    tif.req_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
    req(1'b0, 5'h08, 32'h0);
    check("t6_cnt_restart", tif.rsp_rdata, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
